lsu: RTL

Load/store unit for the hxd32 execute stage. It sits directly downstream of the ALU and takes the ALU result as the effective address of a load or store. It runs one data-bus transaction per request: byte-enable and write-data lane steering, misalignment detection, and sign/zero extension of load data. It holds the pipeline through a stall output until the access completes.

---
 rtl/lsu.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// Load/store unit for the hxd32 execute stage.
// Takes the ALU result as the effective address, runs one data-bus
// transaction per request, steers store lanes, flags misaligned/reserved
// accesses, and sign/zero-extends load data. stall_o holds the pipeline
// until the access completes.
//
// Bus handshake: dbus_req_o stays high, with addr/we/be/wdata held stable
// from registers, until dbus_gnt_i is seen in the same cycle (request
// accepted at that edge). For loads, read data is taken on the first
// dbus_rvalid_i after the grant cycle; gnt and rvalid are ignored in every
// other state, including an rvalid coincident with the grant.
module lsu #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            req_i,
  input  logic            we_i,
  input  logic [1:0]      size_i,
  input  logic            unsigned_i,
  input  logic [XLEN-1:0] addr_i,
  input  logic [XLEN-1:0] wdata_i,
  output logic            stall_o,
  output logic            done_o,
  output logic            misalign_o,
  output logic [XLEN-1:0] rdata_o,
  output logic            dbus_req_o,
  output logic            dbus_we_o,
  output logic [XLEN-1:0] dbus_addr_o,
  output logic [3:0]      dbus_be_o,
  output logic [XLEN-1:0] dbus_wdata_o,
  input  logic            dbus_gnt_i,
  input  logic            dbus_rvalid_i,
  input  logic [XLEN-1:0] dbus_rdata_i,
  output logic [2:0]      dbg_state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [1:0]        off_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [3:0]        be_q;
  logic [XLEN-1:0]   rdata_q;

  logic              misalign;
  logic              accept;
  logic [3:0]        be_steer;
  logic [XLEN-1:0]   wdata_steer;
  logic [7:0]        rbyte;
  logic [15:0]       rhalf;
  logic [XLEN-1:0]   ld_fmt;

  // Classify the incoming request: reserved size or address not a multiple of the size.
  always_comb begin
    misalign = (size_i == 2'b11) ||
               ((size_i == 2'b01) && addr_i[0]) ||
               ((size_i == 2'b10) && (addr_i[1:0] != 2'b00));
    accept   = (state_q == S_IDLE) && req_i && !misalign;
  end

  // Replicate store data across lanes and pick byte enables from the low address bits.
  always_comb begin
    be_steer    = 4'b1111;
    wdata_steer = wdata_i;
    case (size_i)
      2'b00: begin
        be_steer    = 4'b0001 << addr_i[1:0];
        wdata_steer = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        be_steer    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_steer = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  // Extract the addressed byte/half from the bus word and extend it.
  always_comb begin
    case (off_q)
      2'd0:    rbyte = dbus_rdata_i[7:0];
      2'd1:    rbyte = dbus_rdata_i[15:8];
      2'd2:    rbyte = dbus_rdata_i[23:16];
      default: rbyte = dbus_rdata_i[31:24];
    endcase
    rhalf = off_q[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];
    case (size_q)
      2'b00:   ld_fmt = {{24{!uns_q && rbyte[7]}}, rbyte};
      2'b01:   ld_fmt = {{16{!uns_q && rhalf[15]}}, rhalf};
      default: ld_fmt = dbus_rdata_i;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_i) state_d = misalign ? S_ERR : S_REQ;
      S_REQ:   if (dbus_gnt_i) state_d = we_q ? S_DONE : S_WAIT;
      S_WAIT:  if (dbus_rvalid_i) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM outputs; stall covers the accepting IDLE cycle so the EX stage holds immediately.
  always_comb begin
    stall_o     = accept || (state_q == S_REQ) || (state_q == S_WAIT);
    done_o      = (state_q == S_DONE);
    misalign_o  = (state_q == S_ERR);
    dbus_req_o  = (state_q == S_REQ);
    dbg_state_o = state_q;
  end

  // Capture the accepted request so the bus sees stable values for the whole transaction.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      we_q    <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      off_q   <= 2'b00;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= 4'b0000;
    end else if (accept) begin
      we_q    <= we_i;
      size_q  <= size_i;
      uns_q   <= unsigned_i;
      off_q   <= addr_i[1:0];
      addr_q  <= {addr_i[XLEN-1:2], 2'b00};
      wdata_q <= wdata_steer;
      be_q    <= be_steer;
    end
  end

  // Load result register; only a completing load updates it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                     rdata_q <= '0;
    else if ((state_q == S_WAIT) && dbus_rvalid_i) rdata_q <= ld_fmt;
  end

  assign dbus_we_o    = we_q;
  assign dbus_addr_o  = addr_q;
  assign dbus_be_o    = be_q;
  assign dbus_wdata_o = wdata_q;
  assign rdata_o      = rdata_q;

endmodule
